flux_rr_scheduler: RTL
======================

Name: flux_rr_scheduler

Overview:
- Shared-actor flux scheduler for the multi-flux HEVC actors (line buffer, filters). It replaces the fixed lowest-index tag priority with round-robin arbitration.
- Each flux computes a per-flux fire condition (req) and a last-token-of-block flag (last). The scheduler returns a one-hot grant plus a tag in the same cycle; the actor uses that tag to index its per-flux state.
- A flux keeps ownership for a burst of consecutive firings until block end, quantum expiry or stall timeout.

Parameters:
- FLUX, 2, number of interleaved data fluxes (>=2, need not be a power of 2).
- TAG_WIDTH, $clog2(FLUX), width of grant_tag.
- MAX_BURST, 16, maximum consecutive grants to one owner before forced release; 0 = unlimited.
- STALL_LIMIT, 4, consecutive cycles the owner may leave req low before losing the lock; 0 = release on the first idle cycle.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-low reset.
- req  input  FLUX  req[i]=1: flux i can fire this cycle.
- last  input  FLUX  last[i]=1: a firing of flux i completes its block (e.g. line buffer returning to IDLE).
- grant  output  FLUX  one-hot grant, combinational from req/last and registered state.
- grant_tag  output  TAG_WIDTH  index of the granted flux; 0 when grant_valid=0.
- grant_valid  output  1  OR of grant; when high the actor fires flux grant_tag this cycle.
- owner_lock  output  1  registered; 1 in LOCKED state.
- stat_sel  input  TAG_WIDTH  statistics select (see Optional Feature).
- stat_cnt  output  16  statistics read data (see Optional Feature).

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, ptr=0, owner=0, burst_cnt=0, stall_cnt=0. While rst==0, grant, grant_tag and grant_valid are forced to 0 combinationally.
- Zero latency: grant is valid in the same cycle as req. Every grant is a firing; there is no separate accept.
- IDLE:
  - Search for the first i with req[i]=1, scanning from ptr upward with wrap FLUX-1 -> 0.
  - No request: grant=0, no state change.
  - Grant g with last[g]=1: stay IDLE, ptr <= (g+1) mod FLUX.
  - Grant g with last[g]=0: go LOCKED, owner <= g, burst_cnt <= 1, stall_cnt <= 0. If MAX_BURST==1, stay IDLE and set ptr <= g+1 instead.
- LOCKED (only owner is eligible; other flux reqs are ignored):
  - req[owner]=1: grant owner, burst_cnt++, stall_cnt <= 0.
    - Release (IDLE, ptr <= owner+1 mod FLUX) if last[owner]=1, or if MAX_BURST!=0 and burst_cnt+1==MAX_BURST.
  - req[owner]=0: grant=0, stall_cnt++. Release when stall_cnt+1 > STALL_LIMIT.
  - The release cycle still grants the owner if req[owner]=1. The new arbitration happens the following cycle; there is no dead cycle beyond that.
- Simultaneous last and quantum expiry: a single release, ptr <= owner+1.
- ptr and owner always stay in 0..FLUX-1. Wrap uses explicit compare, not a power-of-2 mask.
- Counters: burst_cnt is $clog2(MAX_BURST+1) bits, minimum 1. stall_cnt is $clog2(STALL_LIMIT+2) bits and saturates.
- Reset mid-burst drops the lock. The actor's per-flux state is independent, so the interrupted flux simply re-arbitrates later.
- Fairness: with all req high and last low, each flux gets at most MAX_BURST consecutive grants, then ownership rotates in index order.

Optional Feature:
- Macro FLUX_SCHED_STATS_EN.
- Defined: per-flux 16-bit grant counters, increment on each grant to that flux, saturate at 16'hFFFF, cleared by reset. stat_cnt = counter[stat_sel] registered, 1-cycle read latency. stat_sel >= FLUX returns 0.
- Undefined: no counters, stat_cnt tied to 0, stat_sel unused.

Test Plan (FLUX=2, MAX_BURST=4, STALL_LIMIT=2 unless noted):
- Reset: rst=0 with req=2'b11 -> grant=0, grant_valid=0. After rst=1 with req=2'b11 and last=0: first grant=2'b01, owner_lock=1 next cycle.
- Quantum: req=2'b11, last=0 for 10 cycles -> grant_tag sequence 0,0,0,0,1,1,1,1,0,0.
- Block end: req=2'b11, last[0] pulsed on the 2nd grant -> tags 0,0,1,1,1,1,0. ptr wraps to 0 after flux 1 releases.
- Stall: owner 0 locked, req=2'b10 for 4 cycles -> grant=0 for 3 cycles, lock released, grant=2'b10 on the 4th cycle. Flux 1 stays blocked while the owner is merely stalled.
- Non-power-of-2 (FLUX=3, MAX_BURST=1): req=3'b111 -> tags 0,1,2,0,1,2. Tags 3 and above never appear.
- FLUX_SCHED_STATS_EN: after the quantum test, stat_sel=0 -> stat_cnt=6 and stat_sel=1 -> stat_cnt=4 one cycle later. Force 70000 grants to flux 0 -> stat_cnt=16'hFFFF.

Source files
------------

// File: rtl/flux_rr_scheduler.sv
// flux_rr_scheduler: round-robin flux scheduler for shared multi-flux actors.
// Returns a one-hot grant and a tag in the same cycle as req. A flux that fires
// without completing its block holds ownership until one of three things happens:
// its block ends, its burst quantum expires, or it stalls for too long.
// Optional macro FLUX_SCHED_STATS_EN adds per-flux saturating grant counters
// that are read through stat_sel/stat_cnt. Without it, stat_cnt is tied to 0.

`ifdef FLUX_SCHED_STATS_EN
// Per-flux 16-bit saturating grant counter.
module flux_sched_stat_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);
  // count grants, stick at all-ones
  always_ff @(posedge clk) begin
    if (!rst)                        cnt <= '0;
    else if (inc && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end
endmodule
`endif

module flux_rr_scheduler #(
  parameter int FLUX        = 2,
  parameter int TAG_WIDTH   = $clog2(FLUX),
  parameter int MAX_BURST   = 16,
  parameter int STALL_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLUX-1:0]      req,
  input  logic [FLUX-1:0]      last,
  output logic [FLUX-1:0]      grant,
  output logic [TAG_WIDTH-1:0] grant_tag,
  output logic                 grant_valid,
  output logic                 owner_lock,
  input  logic [TAG_WIDTH-1:0] stat_sel,
  output logic [15:0]          stat_cnt
);

  localparam int BW_RAW = $clog2(MAX_BURST + 1);
  localparam int BW     = (BW_RAW < 1) ? 1 : BW_RAW;
  localparam int SW_RAW = $clog2(STALL_LIMIT + 2);
  localparam int SW     = (SW_RAW < 1) ? 1 : SW_RAW;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t               state_q, state_d;
  logic [TAG_WIDTH-1:0] ptr_q, ptr_d;
  logic [TAG_WIDTH-1:0] owner_q, owner_d;
  logic [BW-1:0]        burst_q, burst_d;
  logic [SW-1:0]        stall_q, stall_d;

  logic                 arb_hit;
  logic [TAG_WIDTH-1:0] arb_idx;
  logic                 gnt_hit;
  logic [TAG_WIDTH-1:0] gnt_idx;
  logic                 fire;

  // (i+1) mod FLUX by explicit compare, so FLUX need not be a power of 2
  function automatic logic [TAG_WIDTH-1:0] wrap_inc(input logic [TAG_WIDTH-1:0] i);
    if (int'(i) >= FLUX - 1) return '0;
    return i + TAG_WIDTH'(1);
  endfunction

  // first requester at or after ptr, wrapping past FLUX-1 back to 0
  always_comb begin
    int                   c;
    logic [TAG_WIDTH-1:0] cidx;
    arb_hit = 1'b0;
    arb_idx = '0;
    c       = 0;
    cidx    = '0;
    for (int k = 0; k < FLUX; k++) begin
      c = int'(ptr_q) + k;
      if (c >= FLUX) c = c - FLUX;
      cidx = TAG_WIDTH'(c);
      if (!arb_hit && req[cidx]) begin
        arb_hit = 1'b1;
        arb_idx = cidx;
      end
    end
  end

  // next-state and grant selection; a release cycle still grants the owner
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    burst_d = burst_q;
    stall_d = stall_q;
    gnt_hit = 1'b0;
    gnt_idx = '0;
    case (state_q)
      S_IDLE: begin
        if (arb_hit) begin
          gnt_hit = 1'b1;
          gnt_idx = arb_idx;
          // a single-token block or a quantum of one never takes the lock
          if (last[arb_idx] || MAX_BURST == 1) begin
            ptr_d = wrap_inc(arb_idx);
          end else begin
            state_d = S_LOCKED;
            owner_d = arb_idx;
            burst_d = BW'(1);
            stall_d = '0;
          end
        end
      end
      S_LOCKED: begin
        if (req[owner_q]) begin
          gnt_hit = 1'b1;
          gnt_idx = owner_q;
          stall_d = '0;
          if (burst_q != '1) burst_d = burst_q + BW'(1);
          // block end and quantum expiry collapse into one release
          if (last[owner_q] || (MAX_BURST != 0 && int'(burst_q) + 1 == MAX_BURST)) begin
            state_d = S_IDLE;
            ptr_d   = wrap_inc(owner_q);
          end
        end else begin
          if (stall_q != '1) stall_d = stall_q + SW'(1);
          if (int'(stall_q) + 1 > STALL_LIMIT) begin
            state_d = S_IDLE;
            ptr_d   = wrap_inc(owner_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // scheduler state registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      burst_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      stall_q <= stall_d;
    end
  end

  // grant outputs are forced low while reset is asserted
  always_comb begin
    fire        = rst && gnt_hit;
    grant       = '0;
    for (int i = 0; i < FLUX; i++) grant[i] = fire && (gnt_idx == TAG_WIDTH'(i));
    grant_tag   = fire ? gnt_idx : '0;
    grant_valid = fire;
  end

  assign owner_lock = (state_q == S_LOCKED);

`ifdef FLUX_SCHED_STATS_EN
  logic [FLUX-1:0][15:0] cnt;

  for (genvar g = 0; g < FLUX; g++) begin : g_stat
    flux_sched_stat_ctr u_ctr (
      .clk (clk),
      .rst (rst),
      .inc (grant[g]),
      .cnt (cnt[g])
    );
  end

  // registered read port, out-of-range selects read 0
  always_ff @(posedge clk) begin
    if (!rst)                     stat_cnt <= '0;
    else if (int'(stat_sel) < FLUX) stat_cnt <= cnt[stat_sel];
    else                          stat_cnt <= '0;
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule
